midi_rx: RTL and testbench

- Receive end of the sequencer's MIDI link: deserialises the 31250-baud MIDI serial line and decodes Note On and Note Off messages into parallel note events.
- Sits beside `top`, feeding external controller input (transpose or seed keys) into the generative sequencer core.
- Handles running status, interleaved system real-time bytes, glitches and framing errors.

---
 rtl/midi_pkg.sv | 35 +++
 rtl/midi_uart_rx.sv | 106 ++++++++++
 rtl/midi_rx.sv | 97 +++++++++
 tb/tb_midi_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI receive types and status-byte constants for the sequencer's
// controller input path.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [2:0] {
        U_WAIT_IDLE,
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_EXPECT_D1,
        P_EXPECT_D2
    } parser_state_t;

    typedef struct packed {
        logic       is_on;
        logic [3:0] channel;
        logic [6:0] note;
        logic [6:0] velocity;
    } note_msg_t;

    // Status bytes that open a note message (0x80-0x9F).
    function automatic logic is_note_status(input logic [7:0] b);
        return (b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON);
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial deserialiser: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling, and stop-bit framing check.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       framing_error,
    output logic       rx_active
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       sync_q;
    logic             line;
    logic             line_prev;
    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign line = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Line idles high, so the synchroniser and edge history reset high
            // to avoid a false start edge right after reset.
            sync_q        <= 2'b11;
            line_prev     <= 1'b1;
            state         <= U_WAIT_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_byte       <= '0;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            rx_active     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], midi_in};
            line_prev  <= line;
            // NOTE: non-blocking defaults first; a later assignment in the case
            // below overrides them within the same clock.
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            cnt           <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

            case (state)
                U_WAIT_IDLE: begin
                    if (line) state <= U_IDLE;
                end
                U_IDLE: begin
                    if (line_prev && !line) begin
                        state     <= U_START;
                        cnt       <= '0;
                        rx_active <= 1'b1;
                    end
                end
                U_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (line) begin
                            state     <= U_IDLE;
                            rx_active <= 1'b0;
                        end else begin
                            state   <= U_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                U_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {line, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= U_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                U_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        rx_active <= 1'b0;
                        if (line) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                            state      <= U_IDLE;
                        end else begin
                            // Low stop bit (or break): resync only once the line idles.
                            framing_error <= 1'b1;
                            state         <= U_WAIT_IDLE;
                        end
                    end
                end
                default: state <= U_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/midi_rx.sv
// MIDI receiver top: UART front end plus a running-status parser that turns
// Note On / Note Off messages into registered note events.
module midi_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 31250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic       msg_valid,
    output logic       msg_is_on,
    output logic [3:0] msg_channel,
    output logic [6:0] msg_note,
    output logic [6:0] msg_velocity,
    output logic       framing_error,
    output logic       rx_active
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    logic [7:0]    rx_byte;
    logic          byte_valid;
    parser_state_t p_state;
    logic [7:0]    rs_status;
    logic          rs_valid;
    logic [6:0]    d1;
    note_msg_t     msg_q;

    midi_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk          (clk),
        .rst_n        (rst_n),
        .midi_in      (midi_in),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .framing_error(framing_error),
        .rx_active    (rx_active)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state   <= P_IDLE;
            rs_status <= '0;
            rs_valid  <= 1'b0;
            d1        <= '0;
            msg_q     <= '0;
            msg_valid <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            if (framing_error) begin
                rs_valid <= 1'b0;
                p_state  <= P_IDLE;
            end else if (byte_valid && (rx_byte < REALTIME_MIN)) begin
                // Real-time bytes fall through untouched so they can sit mid-message.
                if (is_note_status(rx_byte)) begin
                    rs_status <= rx_byte;
                    rs_valid  <= 1'b1;
                    p_state   <= P_EXPECT_D1;
                end else if (rx_byte[7]) begin
                    rs_valid <= 1'b0;
                    p_state  <= P_IDLE;
                end else begin
                    case (p_state)
                        P_IDLE: begin
                            if (rs_valid) begin
                                d1      <= rx_byte[6:0];
                                p_state <= P_EXPECT_D2;
                            end
                        end
                        P_EXPECT_D1: begin
                            d1      <= rx_byte[6:0];
                            p_state <= P_EXPECT_D2;
                        end
                        P_EXPECT_D2: begin
                            msg_q.is_on    <= (rs_status[7:4] == NOTE_ON) && (rx_byte[6:0] != 7'd0);
                            msg_q.channel  <= rs_status[3:0];
                            msg_q.note     <= d1;
                            msg_q.velocity <= rx_byte[6:0];
                            msg_valid      <= 1'b1;
                            p_state        <= P_EXPECT_D1;
                        end
                        default: p_state <= P_IDLE;
                    endcase
                end
            end
        end
    end

    assign msg_is_on    = msg_q.is_on;
    assign msg_channel  = msg_q.channel;
    assign msg_note     = msg_q.note;
    assign msg_velocity = msg_q.velocity;

endmodule

// File: tb/tb_midi_rx.sv
// Scoreboard bench for midi_rx, run at a scaled clock so one bit is 32 clocks.
module tb_midi_rx;
    import midi_pkg::*;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD        = 31250;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;

    logic       clk;
    logic       rst_n;
    logic       midi_in;
    logic       msg_valid;
    logic       msg_is_on;
    logic [3:0] msg_channel;
    logic [6:0] msg_note;
    logic [6:0] msg_velocity;
    logic       framing_error;
    logic       rx_active;

    int checks   = 0;
    int failures = 0;
    int msg_seen = 0;
    int fe_seen  = 0;
    note_msg_t exp_q[$];

    midi_rx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .midi_in      (midi_in),
        .msg_valid    (msg_valid),
        .msg_is_on    (msg_is_on),
        .msg_channel  (msg_channel),
        .msg_note     (msg_note),
        .msg_velocity (msg_velocity),
        .framing_error(framing_error),
        .rx_active    (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic push_exp(input logic is_on, input logic [3:0] ch, input logic [6:0] note,
                            input logic [6:0] vel);
        note_msg_t m;
        m.is_on    = is_on;
        m.channel  = ch;
        m.note     = note;
        m.velocity = vel;
        exp_q.push_back(m);
    endtask

    task automatic bit_time(input logic v);
        midi_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_level);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) check("rx_active_mid_frame", 32'(rx_active), 32'd1);
            bit_time(b[i]);
        end
        bit_time(stop_level);
        if (!stop_level) bit_time(1'b1);
    endtask

    // Scoreboard: every msg_valid pulse must match the oldest expected message.
    always @(negedge clk) begin
        note_msg_t e;
        if (rst_n && framing_error) fe_seen++;
        if (rst_n && msg_valid) begin
            msg_seen++;
            check("msg_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("msg_is_on",    32'(msg_is_on),    32'(e.is_on));
                check("msg_channel",  32'(msg_channel),  32'(e.channel));
                check("msg_note",     32'(msg_note),     32'(e.note));
                check("msg_velocity", 32'(msg_velocity), 32'(e.velocity));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        midi_in = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_msg_valid",     32'(msg_valid),     32'd0);
        check("rst_msg_is_on",     32'(msg_is_on),     32'd0);
        check("rst_msg_channel",   32'(msg_channel),   32'd0);
        check("rst_msg_note",      32'(msg_note),      32'd0);
        check("rst_msg_velocity",  32'(msg_velocity),  32'd0);
        check("rst_framing_error", 32'(framing_error), 32'd0);
        check("rst_rx_active",     32'(rx_active),     32'd0);
        rst_n = 1'b1;
        repeat (10 * CPB) @(negedge clk);
        check("idle_no_msg",   32'(msg_seen),  32'd0);
        check("idle_no_fe",    32'(fe_seen),   32'd0);
        check("idle_rx_active", 32'(rx_active), 32'd0);

        // Basic Note On
        push_exp(1'b1, 4'd3, 7'd60, 7'd100);
        send_byte(8'h93, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        repeat (4) @(negedge clk);
        check("basic_count", 32'(msg_seen), 32'd1);

        // Running status, velocity 0 reads as Note Off
        push_exp(1'b0, 4'd3, 7'd62, 7'd0);
        send_byte(8'h3E, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (CPB) @(negedge clk);
        check("running_count", 32'(msg_seen),    32'd2);
        check("hold_note",     32'(msg_note),    32'd62);
        check("hold_channel",  32'(msg_channel), 32'd3);
        check("pulse_width",   32'(msg_valid),   32'd0);

        // Real-time byte between d1 and d2
        push_exp(1'b0, 4'd0, 7'd64, 7'd127);
        send_byte(8'h80, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h7F, 1'b1);
        repeat (4) @(negedge clk);
        check("realtime_count", 32'(msg_seen), 32'd3);

        // Framing error clears running status
        send_byte(8'h00, 1'b0);
        send_byte(8'h45, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (4) @(negedge clk);
        check("framing_fe_count",  32'(fe_seen),  32'd1);
        check("framing_msg_count", 32'(msg_seen), 32'd3);

        // 0xB0 (non-note status) clears running status
        push_exp(1'b1, 4'd2, 7'd48, 7'd64);
        send_byte(8'h92, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'hB0, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b1);
        repeat (4) @(negedge clk);
        check("status_b0_count", 32'(msg_seen), 32'd4);

        // 0xF7 is the highest byte that still clears running status
        send_byte(8'h9F, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hF7, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        repeat (4) @(negedge clk);
        check("status_f7_count", 32'(msg_seen), 32'd4);

        // 0xFF is ignored; channel 15, extreme data values
        push_exp(1'b1, 4'd15, 7'd127, 7'd1);
        send_byte(8'h9F, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        check("realtime_ff_count", 32'(msg_seen), 32'd5);

        // Short glitch shorter than half a bit
        midi_in = 1'b0;
        repeat (CPB / 3) @(negedge clk);
        midi_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_fe_count",  32'(fe_seen),   32'd1);
        check("glitch_msg_count", 32'(msg_seen),  32'd5);
        check("glitch_rx_active", 32'(rx_active), 32'd0);

        // Reset during bit 4 of a 0x90 frame, with running status armed beforehand
        send_byte(8'h91, 1'b1);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0);
        midi_in = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rx_active", 32'(rx_active), 32'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h40, 1'b1);
        send_byte(8'h50, 1'b1);
        repeat (4) @(negedge clk);
        check("midrst_msg_count", 32'(msg_seen), 32'd5);
        check("midrst_fe_count",  32'(fe_seen),  32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
